// File: rtl/cpu_pkg.sv
// Shared encodings for the branch resolve/predict slice: branch kinds,
// 2-bit counter values and the table-clear sequencer states.
package cpu_pkg;

   localparam logic [2:0] BR_BEQ  = 3'd0;
   localparam logic [2:0] BR_BNE  = 3'd1;
   localparam logic [2:0] BR_BGTZ = 3'd2;
   localparam logic [2:0] BR_BLEZ = 3'd3;
   localparam logic [2:0] BR_BLTZ = 3'd4;
   localparam logic [2:0] BR_BGEZ = 3'd5;

   localparam logic [1:0] CNT_SN = 2'b00;
   localparam logic [1:0] CNT_WN = 2'b01;
   localparam logic [1:0] CNT_WT = 2'b10;
   localparam logic [1:0] CNT_ST = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
   import cpu_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       taken,
   output logic [1:0] nxt
);

   always_comb begin
      nxt = cnt;
      if (taken) begin
         if (cnt != CNT_ST) nxt = cnt + 2'd1;
      end else begin
         if (cnt != CNT_SN) nxt = cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_resolve_predict.sv
// Branch resolution for six MIPS conditional branches plus a direct-mapped
// 2-bit BHT predictor, misprediction flag, statistics and a table-clear FSM.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | table live: predictions served, legal resolves train it
//   ST_CLEAR | one entry per cycle rewritten to weakly not-taken, busy=1
module branch_resolve_predict
   import cpu_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PC_W      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   pred_pc,
   output logic              pred_taken,
   input  logic              res_valid,
   input  logic [PC_W-1:0]   res_pc,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [2:0]        branch_op,
   input  logic              res_pred_taken,
   output logic              res_taken,
   output logic              mispredict,
   input  logic              clear_req,
   output logic              busy,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  mispredict_count
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]       bht [BHT_DEPTH];
   clr_state_t       state;
   logic [IDX_W-1:0] clr_idx;
   logic [IDX_W-1:0] res_idx;
   logic [IDX_W-1:0] pred_idx;
   logic             legal;
   logic             cond;
   logic             rs_neg;
   logic             rs_zero;
   logic             resolved;
   logic             upd_en;
   logic [1:0]       upd_cnt;
   logic             unused_pc_bits;

   assign res_idx  = res_pc[IDX_W+1:2];
   assign pred_idx = pred_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{res_pc[PC_W-1:IDX_W+2], res_pc[1:0],
                             pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

   // Signed compares against zero reduce to the sign bit and a zero test.
   assign rs_neg  = rs_data[DATA_W-1];
   assign rs_zero = (rs_data == '0);
   assign legal   = (branch_op <= BR_BGEZ);

   always_comb begin
      cond = 1'b0;
      case (branch_op)
         BR_BEQ:  cond = (rs_data == rt_data);
         BR_BNE:  cond = (rs_data != rt_data);
         BR_BGTZ: cond = ~rs_neg & ~rs_zero;
         BR_BLEZ: cond = rs_neg | rs_zero;
         BR_BLTZ: cond = rs_neg;
         BR_BGEZ: cond = ~rs_neg;
         default: cond = 1'b0;
      endcase
   end

   assign resolved   = res_valid & legal;
   assign res_taken  = resolved & cond;
   assign mispredict = resolved & (res_taken != res_pred_taken);

   assign busy       = (state == ST_CLEAR);
   assign pred_taken = ~busy & bht[pred_idx][1];
   assign upd_en     = resolved & (state == ST_IDLE) & ~clear_req;

   sat_counter2 u_sat (
      .cnt   (bht[res_idx]),
      .taken (res_taken),
      .nxt   (upd_cnt)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_WN;
      end else if (state == ST_CLEAR) begin
         bht[clr_idx] <= CNT_WN;
      end else if (upd_en) begin
         bht[res_idx] <= upd_cnt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         clr_idx <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (clear_req) begin
                  state   <= ST_CLEAR;
                  clr_idx <= '0;
               end
            end
            ST_CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == IDX_W'(BHT_DEPTH - 1)) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Statistics keep counting through a clear and stick at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (resolved && (branch_count != '1))
            branch_count <= branch_count + 1'b1;
         if (mispredict && (mispredict_count != '1))
            mispredict_count <= mispredict_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a behavioural model of the resolver, BHT, statistics and clear.
module tb_branch_resolve_predict;

   localparam int DATA_W    = 32;
   localparam int PC_W      = 32;
   localparam int BHT_DEPTH = 64;
   localparam int CNT_W     = 8;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [PC_W-1:0]   pred_pc = '0;
   logic              pred_taken;
   logic              res_valid = 1'b0;
   logic [PC_W-1:0]   res_pc = '0;
   logic [DATA_W-1:0] rs_data = '0;
   logic [DATA_W-1:0] rt_data = '0;
   logic [2:0]        branch_op = '0;
   logic              res_pred_taken = 1'b0;
   logic              res_taken;
   logic              mispredict;
   logic              clear_req = 1'b0;
   logic              busy;
   logic [CNT_W-1:0]  branch_count;
   logic [CNT_W-1:0]  mispredict_count;

   branch_resolve_predict #(
      .DATA_W(DATA_W), .PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .res_valid(res_valid), .res_pc(res_pc), .rs_data(rs_data),
      .rt_data(rt_data), .branch_op(branch_op),
      .res_pred_taken(res_pred_taken), .res_taken(res_taken),
      .mispredict(mispredict), .clear_req(clear_req), .busy(busy),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_bht [BHT_DEPTH];
   int m_bc, m_mc, m_clear_left;

   // DUT values captured by the last step, for directed checks
   logic s_taken, s_mis, s_pred, s_busy;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % BHT_DEPTH);
   endfunction

   function automatic bit branch_cond(input logic [2:0] op,
                                      input logic [31:0] rs,
                                      input logic [31:0] rt);
      case (op)
         3'd0: return rs == rt;
         3'd1: return rs != rt;
         3'd2: return $signed(rs) > 0;
         3'd3: return $signed(rs) <= 0;
         3'd4: return $signed(rs) < 0;
         3'd5: return $signed(rs) >= 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
      m_bc = 0;
      m_mc = 0;
      m_clear_left = 0;
   endtask

   // One clock: drive, check combinational outputs, clock, advance model,
   // check registered outputs. Entered and left 1 time unit after a posedge.
   task automatic step(input logic v, input logic [31:0] pc,
                       input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic pt,
                       input logic clr, input logic [31:0] ppc);
      bit legal, tk, mis, bsy, exp_pred;
      int ri;
      res_valid = v; res_pc = pc; branch_op = op; rs_data = rs;
      rt_data = rt; res_pred_taken = pt; clear_req = clr; pred_pc = ppc;
      #2;
      legal = (op <= 3'd5);
      bsy = (m_clear_left > 0);
      tk  = v && legal && branch_cond(op, rs, rt);
      mis = v && legal && (tk != pt);
      exp_pred = bsy ? 1'b0 : (m_bht[idx_of(ppc)] >= 2);
      check_val("res_taken", 32'(res_taken), 32'(tk));
      check_val("mispredict", 32'(mispredict), 32'(mis));
      check_val("pred_taken", 32'(pred_taken), 32'(exp_pred));
      s_taken = res_taken; s_mis = mispredict; s_pred = pred_taken;
      @(posedge clk);
      if (v && legal) begin
         if (m_bc < CNT_MAX) m_bc++;
         if (mis && m_mc < CNT_MAX) m_mc++;
      end
      ri = idx_of(pc);
      if (!bsy && !clr && v && legal) begin
         if (tk) m_bht[ri] = (m_bht[ri] == 3) ? 3 : m_bht[ri] + 1;
         else    m_bht[ri] = (m_bht[ri] == 0) ? 0 : m_bht[ri] - 1;
      end
      // predictions are masked and training dropped while clearing, so the
      // model can restore every entry at the start of a clear
      if (!bsy && clr) begin
         m_clear_left = BHT_DEPTH;
         for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
      end else if (bsy) begin
         m_clear_left--;
      end
      #1;
      check_val("busy", 32'(busy), 32'(m_clear_left > 0));
      check_val("branch_count", 32'(branch_count), 32'(m_bc));
      check_val("mispredict_count", 32'(mispredict_count), 32'(m_mc));
      s_busy = busy;
   endtask

   task automatic idle(input logic [31:0] ppc);
      step(1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, ppc);
   endtask

   function automatic logic [31:0] pick_rs();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hffff_ffff;
         3: return 32'h8000_0000;
         4: return 32'h7fff_ffff;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int nbusy;
      logic [31:0] rs, rt, pc, ppc;
      model_reset();
      #12 reset = 1'b1;
      @(posedge clk); #1;

      // reset state
      idle(32'h3000);
      check_val("reset_pred", 32'(s_pred), 32'h0);
      check_val("reset_bc", 32'(branch_count), 32'h0);
      check_val("reset_busy", 32'(s_busy), 32'h0);

      // comparator corners
      step(1'b1, 32'h3100, 3'd2, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h3000);
      check_val("bgtz_neg", 32'(s_taken), 32'h0);
      step(1'b1, 32'h3100, 3'd5, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3000);
      check_val("bgez_zero", 32'(s_taken), 32'h1);
      step(1'b1, 32'h3100, 3'd3, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3000);
      check_val("blez_zero", 32'(s_taken), 32'h1);
      step(1'b1, 32'h3100, 3'd1, 32'h5, 32'h5, 1'b0, 1'b0, 32'h3000);
      check_val("bne_equal", 32'(s_taken), 32'h0);
      step(1'b1, 32'h3100, 3'd7, 32'h5, 32'h5, 1'b1, 1'b0, 32'h3000);
      check_val("illegal_taken", 32'(s_taken), 32'h0);
      check_val("illegal_bc", 32'(branch_count), 32'h4);
      check_val("illegal_mc", 32'(mispredict_count), 32'h0);

      // training at 0x3010
      step(1'b1, 32'h3010, 3'd0, 32'h7, 32'h7, 1'b0, 1'b0, 32'h3010);
      check_val("train_mis1", 32'(s_mis), 32'h1);
      check_val("train_pred_same_cycle", 32'(s_pred), 32'h0);
      check_val("train_mc1", 32'(mispredict_count), 32'h1);
      idle(32'h3010);
      check_val("train_pred1", 32'(s_pred), 32'h1);
      step(1'b1, 32'h3010, 3'd0, 32'h7, 32'h7, 1'b1, 1'b0, 32'h3010);
      step(1'b1, 32'h3010, 3'd0, 32'h7, 32'h7, 1'b1, 1'b0, 32'h3010);
      step(1'b1, 32'h3010, 3'd0, 32'h1, 32'h2, 1'b1, 1'b0, 32'h3010);
      check_val("train_mc2", 32'(mispredict_count), 32'h2);
      idle(32'h3010);
      check_val("train_pred_after_nt", 32'(s_pred), 32'h1);

      // aliasing: 0x3010 + 4*depth shares the entry
      step(1'b1, 32'h3010 + 4 * BHT_DEPTH, 3'd1, 32'h3, 32'h3, 1'b0, 1'b0, 32'h3010);
      step(1'b1, 32'h3010 + 4 * BHT_DEPTH, 3'd1, 32'h3, 32'h3, 1'b0, 1'b0, 32'h3010);
      idle(32'h3010);
      check_val("alias_pred", 32'(s_pred), 32'h0);

      // clear with a resolve and a second clear_req in flight
      for (int e = 0; e < 4; e++)
         for (int k = 0; k < 3; k++)
            step(1'b1, 32'h3020 + 32'(4 * e), 3'd4, 32'hffff_fff0, 32'h0, 1'b1, 1'b0, 32'h3020);
      idle(32'h3020);
      check_val("clear_trained", 32'(s_pred), 32'h1);
      step(1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3020);
      nbusy = s_busy ? 1 : 0;
      for (int k = 0; k < 100 && s_busy; k++) begin
         if (k == 10)
            step(1'b1, 32'h3020, 3'd0, 32'h1, 32'h1, 1'b0, 1'b0, 32'h3020);
         else if (k == 20)
            step(1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3024);
         else
            idle(32'h3028);
         if (s_busy) nbusy++;
      end
      check_val("clear_busy_len", 32'(nbusy), 32'(BHT_DEPTH));
      idle(32'h3020);
      check_val("clear_pred", 32'(s_pred), 32'h0);
      step(1'b1, 32'h3020, 3'd5, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3020);
      idle(32'h3020);
      check_val("clear_entry_wn", 32'(s_pred), 32'h1);

      // reset during clear
      step(1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3000);
      for (int k = 0; k < 19; k++) idle(32'h3000);
      #2 reset = 1'b0;
      #1;
      check_val("rst_mid_busy", 32'(busy), 32'h0);
      check_val("rst_mid_bc", 32'(branch_count), 32'h0);
      check_val("rst_mid_mc", 32'(mispredict_count), 32'h0);
      model_reset();
      #2 reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < BHT_DEPTH; i++)
         step(1'b1, 32'(4 * i), 3'd0, 32'h9, 32'h9, 1'b1, 1'b0, 32'(4 * ((i + BHT_DEPTH - 1) % BHT_DEPTH)));

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         pc  = 32'h3000 + 32'(4 * $urandom_range(0, 7)) + (($urandom_range(0, 1) == 1) ? 32'(4 * BHT_DEPTH) : 32'h0);
         ppc = 32'h3000 + 32'(4 * $urandom_range(0, 7));
         rs  = pick_rs();
         rt  = ($urandom_range(0, 1) == 1) ? rs : pick_rs();
         step(1'($urandom_range(0, 3) != 0), pc, 3'($urandom_range(0, 7)), rs, rt,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0), ppc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
